// File: rtl/mul_share_ctrl_if.sv
// Bundle of requester, response and shared-multiplier signals for
// mul_share_ctrl. The controller uses the slave modport; the requesters
// and the multiplier together form the master side.
interface mul_share_ctrl_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [NUM_REQ-1:0]   resp_ready;
    logic [15:0]          resp_result;
    logic [7:0]           mul_a;
    logic [7:0]           mul_b;
    logic [15:0]          mul_result;
    logic                 busy;

    modport slave (
        input  req_valid, req_a, req_b, resp_ready, mul_result,
        output req_ready, resp_valid, resp_result, mul_a, mul_b, busy
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready, mul_result,
        input  req_ready, resp_valid, resp_result, mul_a, mul_b, busy
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer time-sharing one combinational 8x8 multiplier
// among NUM_REQ requesters: grant, one settle cycle, then hold the
// product on the response handshake until the owner takes it.
module mul_share_ctrl #(
    parameter int NUM_REQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mul_share_ctrl_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] r_cur;
    logic [7:0]       r_mul_a;
    logic [7:0]       r_mul_b;
    logic [15:0]      r_res_q;

    logic [7:0]       w_op_a [NUM_REQ];
    logic [7:0]       w_op_b [NUM_REQ];
    logic [IDX_W-1:0] w_grant;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Per-requester operand unpacking and one-hot handshake decode. Both
    // handshake outputs are forced low while reset is asserted.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_op_a[gi] = bus.req_a[8*gi +: 8];
            assign w_op_b[gi] = bus.req_b[8*gi +: 8];
            assign bus.req_ready[gi]  = rst_n && (r_state == S_IDLE) && w_found
                                        && (w_grant == IDX_W'(gi));
            assign bus.resp_valid[gi] = rst_n && (r_state == S_RESP)
                                        && (r_cur == IDX_W'(gi));
        end
    endgenerate

    // Round-robin pick: first valid requester scanning upward from last_grant+1.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // Sequencer: accept in IDLE, capture product after the settle cycle,
    // and only advance the round-robin pointer once the response is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_cur        <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_res_q      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_mul_a <= w_op_a[w_grant];
                        r_mul_b <= w_op_b[w_grant];
                        r_cur   <= w_grant;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_res_q <= bus.mul_result;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready[r_cur]) begin
                        r_last_grant <= r_cur;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mul_a       = r_mul_a;
    assign bus.mul_b       = r_mul_b;
    assign bus.resp_result = r_res_q;
    assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed-sequence bench for mul_share_ctrl with randomized operands,
// checked every cycle against a transaction-level reference model.
module tb_mul_share_ctrl;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_share_ctrl_if #(.NUM_REQ(N)) bus ();

    // The shared multiplier itself.
    assign bus.mul_result = {8'h00, bus.mul_a} * {8'h00, bus.mul_b};

    mul_share_ctrl #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = free, 1 = product settling, 2 = result offered.
    int          m_phase;
    int          m_last;
    int          m_cur;
    logic [15:0] m_shown;
    logic [15:0] m_pending;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [7:0]  opa [N];
    logic [7:0]  opb [N];
    int          grants[$];
    logic [15:0] last_seen;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] v, int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_last    = N - 1;
        m_cur     = 0;
        m_shown   = 16'h0;
        m_pending = 16'h0;
        m_a       = 8'h0;
        m_b       = 8'h0;
    endtask

    task automatic set_op(int i, logic [7:0] a, logic [7:0] b);
        opa[i] = a;
        opb[i] = b;
        bus.req_a[8*i +: 8] = a;
        bus.req_b[8*i +: 8] = b;
    endtask

    // One clock: check outputs against the model, log the accept, step the model.
    task automatic cycle();
        int w;
        logic [N-1:0] er;
        logic [N-1:0] ev;
        #1;
        w  = pick(bus.req_valid, m_last);
        er = '0;
        ev = '0;
        if (rst_n && m_phase == 0 && w >= 0) er = N'(1 << w);
        if (rst_n && m_phase == 2)           ev = N'(1 << m_cur);
        chk("req_ready",   32'(bus.req_ready),   32'(er));
        chk("resp_valid",  32'(bus.resp_valid),  32'(ev));
        chk("busy",        32'(bus.busy),        32'(m_phase != 0));
        chk("resp_result", 32'(bus.resp_result), 32'(m_shown));
        chk("mul_a",       32'(bus.mul_a),       32'(m_a));
        chk("mul_b",       32'(bus.mul_b),       32'(m_b));
        if (bus.resp_valid != '0) last_seen = bus.resp_result;
        for (int i = 0; i < N; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) grants.push_back(i);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (w >= 0) begin
                m_cur     = w;
                m_a       = opa[w];
                m_b       = opb[w];
                m_pending = 16'(int'(opa[w]) * int'(opb[w]));
                m_phase   = 1;
            end
        end else if (m_phase == 1) begin
            m_shown = m_pending;
            m_phase = 2;
        end else if (bus.resp_ready[m_cur]) begin
            m_last  = m_cur;
            m_phase = 0;
        end
        #1;
    endtask

    task automatic run_req(int i, logic [7:0] a, logic [7:0] b);
        set_op(i, a, b);
        bus.req_valid  = N'(1 << i);
        bus.resp_ready = '1;
        cycle();
        bus.req_valid = '0;
        repeat (3) cycle();
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = '0;
        for (int i = 0; i < N; i++) begin
            opa[i] = 8'h0;
            opb[i] = 8'h0;
        end
        last_seen = 16'hDEAD;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state, with a request pending that must not be granted.
        bus.req_valid = 4'b0001;
        cycle();
        cycle();
        bus.req_valid = '0;
        rst_n = 1'b1;
        cycle();

        // Single request from requester 0.
        grants.delete();
        last_seen = 16'hDEAD;
        run_req(0, 8'h0C, 8'h0D);
        chk("prod_0c0d", 32'(last_seen), 32'h009C);
        chk("single_grant_cnt", 32'(grants.size()), 32'd1);
        chk("single_grant_id", 32'(grants[0]), 32'd0);

        // Operand extremes.
        last_seen = 16'hDEAD;
        run_req(1, 8'hFF, 8'hFF);
        chk("prod_ffff", 32'(last_seen), 32'hFE01);
        last_seen = 16'hDEAD;
        run_req(2, 8'h00, 8'hA5);
        chk("prod_00a5", 32'(last_seen), 32'h0000);
        last_seen = 16'hDEAD;
        run_req(3, 8'h01, 8'h80);
        chk("prod_0180", 32'(last_seen), 32'h0080);

        // All requesters valid continuously, distinct random operands.
        for (int i = 0; i < N; i++)
            set_op(i, 8'(i * 64 + int'($urandom_range(0, 63))), 8'($urandom_range(0, 255)));
        grants.delete();
        bus.req_valid  = '1;
        bus.resp_ready = '1;
        repeat (24) cycle();
        bus.req_valid = '0;
        cycle();
        chk("rr_all_cnt", 32'(grants.size()), 32'd8);
        for (int k = 0; k < 8; k++) chk("rr_all_order", 32'(grants[k]), 32'(k % N));

        // Response stall on requester 1 with requester 2 waiting.
        set_op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        set_op(2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        grants.delete();
        bus.req_valid  = 4'b0110;
        bus.resp_ready = 4'b1101;
        cycle();
        bus.req_valid = 4'b0100;
        repeat (11) cycle();
        bus.resp_ready = '1;
        cycle();
        cycle();
        bus.req_valid = '0;
        repeat (3) cycle();
        chk("stall_cnt", 32'(grants.size()), 32'd2);
        chk("stall_first", 32'(grants[0]), 32'd1);
        chk("stall_next", 32'(grants[1]), 32'd2);

        // Round-robin skip over idle requesters.
        run_req(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        set_op(3, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        grants.delete();
        bus.req_valid = 4'b1010;
        repeat (9) cycle();
        bus.req_valid = '0;
        cycle();
        chk("skip_cnt", 32'(grants.size()), 32'd3);
        chk("skip_g0", 32'(grants[0]), 32'd3);
        chk("skip_g1", 32'(grants[1]), 32'd1);
        chk("skip_g2", 32'(grants[2]), 32'd3);

        // Reset during MUL, then during RESP.
        run_req(2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        grants.delete();
        bus.req_valid  = 4'b1010;
        bus.resp_ready = '0;
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        bus.resp_ready = '1;
        cycle();
        bus.req_valid = '0;
        repeat (3) cycle();
        chk("rst_cnt", 32'(grants.size()), 32'd3);
        chk("rst_g0", 32'(grants[0]), 32'd3);
        chk("rst_g1", 32'(grants[1]), 32'd1);
        chk("rst_g2", 32'(grants[2]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
